// File: rtl/hazard_pkg.sv
// hazard_pkg: shared scoreboard entry type, forwarding-select encoding and sizing helper
// for hazard_scoreboard and its per-source matcher.
package hazard_pkg;

   // Entry dst field is sized for the widest supported register file; REG_AW must not exceed it.
   localparam int SB_MAX_AW   = 8;
   localparam int FWD_REGFILE = 0;

   typedef struct packed {
      logic                 valid;
      logic [SB_MAX_AW-1:0] dst;
      logic                 regwrite;
      logic                 is_load;
   } sb_entry_t;

   function automatic int fwd_w(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hazard_sb_match.sv
// hazard_sb_match: priority match of one source register against the scoreboard;
// reports whether a writer is in flight, which entry (youngest wins) and whether it is a load.
module hazard_sb_match
   import hazard_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int REG_AW = 5
) (
   input  sb_entry_t [DEPTH-1:0]         entries_i,
   input  logic [REG_AW-1:0]             src_i,
   input  logic                          use_i,
   output logic                          hit_o,
   output logic [fwd_w(DEPTH)-1:0]       idx_o,
   output logic                          is_load_o
);
   localparam int IW = fwd_w(DEPTH);

   logic [SB_MAX_AW-1:0] src_ext;

   assign src_ext = SB_MAX_AW'(src_i);

   // Scan oldest to youngest so a younger matching writer overrides an older one; $0 never matches.
   always_comb begin
      hit_o     = 1'b0;
      idx_o     = '0;
      is_load_o = 1'b0;
      if (use_i && (src_i != '0)) begin
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entries_i[i].valid && entries_i[i].regwrite && (entries_i[i].dst == src_ext)) begin
               hit_o     = 1'b1;
               idx_o     = IW'(i);
               is_load_o = entries_i[i].is_load;
            end else begin
               hit_o     = hit_o;
            end
         end
      end else begin
         hit_o = 1'b0;
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift-register scoreboard of post-ID writers driving load-use stall and
// registered forwarding selects. Define HAZARD_SB_PERF_EN to add saturating stall/flush counters.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int DEPTH    = 2,
   parameter int LOAD_LAT = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    id_valid,
   input  logic [REG_AW-1:0]       id_rs,
   input  logic [REG_AW-1:0]       id_rt,
   input  logic                    id_use_rs,
   input  logic                    id_use_rt,
   input  logic [REG_AW-1:0]       id_dst,
   input  logic                    id_regwrite,
   input  logic                    id_memread,
   input  logic                    flush,
   output logic                    stall,
   output logic [fwd_w(DEPTH)-1:0] fwd_sel_rs,
   output logic [fwd_w(DEPTH)-1:0] fwd_sel_rt
`ifdef HAZARD_SB_PERF_EN
   ,
   output logic [15:0]             perf_stall_cnt,
   output logic [15:0]             perf_flush_cnt
`endif
);
   localparam int            SW     = fwd_w(DEPTH);
   localparam logic [SW-1:0] LAT_V  = SW'(LOAD_LAT);
   localparam logic [SW-1:0] SEL_RF = SW'(FWD_REGFILE);

   sb_entry_t [DEPTH-1:0] sb_q, sb_d;
   logic [SW-1:0]         fwd_rs_q, fwd_rs_d, fwd_rt_q, fwd_rt_d;
   logic [SW-1:0]         idx_rs, idx_rt;
   logic                  hit_rs, hit_rt, load_rs, load_rt;
   logic                  haz_rs, haz_rt, issue;

   hazard_sb_match #(.DEPTH(DEPTH), .REG_AW(REG_AW)) u_match_rs (
      .entries_i (sb_q),
      .src_i     (id_rs),
      .use_i     (id_use_rs),
      .hit_o     (hit_rs),
      .idx_o     (idx_rs),
      .is_load_o (load_rs)
   );

   hazard_sb_match #(.DEPTH(DEPTH), .REG_AW(REG_AW)) u_match_rt (
      .entries_i (sb_q),
      .src_i     (id_rt),
      .use_i     (id_use_rt),
      .hit_o     (hit_rt),
      .idx_o     (idx_rt),
      .is_load_o (load_rt)
   );

   // A load closer than LOAD_LAT entries has no data yet, so the consumer must wait in ID.
   assign haz_rs = hit_rs & load_rs & (idx_rs < LAT_V);
   assign haz_rt = hit_rt & load_rt & (idx_rt < LAT_V);
   assign stall  = id_valid & ~flush & (haz_rs | haz_rt);
   assign issue  = id_valid & ~flush & ~stall;

   // Age every entry by one stage; entry0 takes the issuing instruction or a bubble.
   always_comb begin
      sb_d = '0;
      for (int i = DEPTH - 1; i > 0; i--) begin
         sb_d[i] = sb_q[i-1];
      end
      if (issue) begin
         sb_d[0].valid    = 1'b1;
         sb_d[0].dst      = SB_MAX_AW'(id_dst);
         sb_d[0].regwrite = id_regwrite;
         sb_d[0].is_load  = id_memread;
      end else begin
         sb_d[0].valid    = 1'b0;
      end
   end

   // Select k means entry k-1 now, which is one stage further along when the consumer reaches EX.
   always_comb begin
      fwd_rs_d = SEL_RF;
      fwd_rt_d = SEL_RF;
      if (issue) begin
         fwd_rs_d = hit_rs ? (idx_rs + SW'(1)) : SEL_RF;
         fwd_rt_d = hit_rt ? (idx_rt + SW'(1)) : SEL_RF;
      end else begin
         fwd_rs_d = SEL_RF;
         fwd_rt_d = SEL_RF;
      end
   end

   // Scoreboard and forwarding-select state.
   always_ff @(posedge clk) begin
      if (reset) begin
         sb_q     <= '0;
         fwd_rs_q <= SEL_RF;
         fwd_rt_q <= SEL_RF;
      end else begin
         sb_q     <= sb_d;
         fwd_rs_q <= fwd_rs_d;
         fwd_rt_q <= fwd_rt_d;
      end
   end

   assign fwd_sel_rs = fwd_rs_q;
   assign fwd_sel_rt = fwd_rt_q;

`ifdef HAZARD_SB_PERF_EN
   logic [15:0] perf_stall_q, perf_flush_q;

   // Saturating event counters for stall and flush cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_q <= 16'h0000;
         perf_flush_q <= 16'h0000;
      end else begin
         if (stall && (perf_stall_q != 16'hFFFF)) begin
            perf_stall_q <= perf_stall_q + 16'd1;
         end
         if (flush && (perf_flush_q != 16'hFFFF)) begin
            perf_flush_q <= perf_flush_q + 16'd1;
         end
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed stimulus on two configurations (DEPTH=2/LOAD_LAT=1 and
// DEPTH=3/LOAD_LAT=2) checked every cycle against an in-flight history model plus literal pins.
module tb_hazard_scoreboard;

   localparam int NC = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, flush;
   logic [4:0] id_rs, id_rt, id_dst;
   logic       st [NC];
   logic [1:0] srs [NC];
   logic [1:0] srt [NC];
`ifdef HAZARD_SB_PERF_EN
   logic [15:0] pst [NC];
   logic [15:0] pfl [NC];
`endif

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   hazard_scoreboard dut0 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
      .stall(st[0]), .fwd_sel_rs(srs[0]), .fwd_sel_rt(srt[0])
`ifdef HAZARD_SB_PERF_EN
      , .perf_stall_cnt(pst[0]), .perf_flush_cnt(pfl[0])
`endif
   );

   hazard_scoreboard #(.DEPTH(3), .LOAD_LAT(2)) dut1 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
      .stall(st[1]), .fwd_sel_rs(srs[1]), .fwd_sel_rt(srt[1])
`ifdef HAZARD_SB_PERF_EN
      , .perf_stall_cnt(pst[1]), .perf_flush_cnt(pfl[1])
`endif
   );

   // Model: history of what left ID each cycle (age 0 = in EX), newest first.
   int         dep_c [NC] = '{2, 3};
   int         lat_c [NC] = '{1, 2};
   logic       mv [NC][8];
   logic [4:0] md [NC][8];
   logic       mw [NC][8];
   logic       ml [NC][8];
   logic [1:0] m_rs [NC];
   logic [1:0] m_rt [NC];
   int         mp_st [NC];
   int         mp_fl [NC];

   function automatic int m_age(int c, logic [4:0] r, logic u);
      if (!u || r == 5'd0) return -1;
      for (int a = 0; a < dep_c[c]; a++)
         if (mv[c][a] && mw[c][a] && md[c][a] == r) return a;
      return -1;
   endfunction

   function automatic logic m_haz(int c, logic [4:0] r, logic u);
      int a;
      a = m_age(c, r, u);
      return (a >= 0) && ml[c][a] && (a < lat_c[c]);
   endfunction

   function automatic logic m_stall(int c);
      return id_valid && !flush && (m_haz(c, id_rs, id_use_rs) || m_haz(c, id_rt, id_use_rt));
   endfunction

   function automatic logic [1:0] m_sel(int c, logic [4:0] r, logic u);
      int a;
      a = m_age(c, r, u);
      if (!id_valid || flush || m_stall(c) || a < 0) return 2'd0;
      return 2'(a + 1);
   endfunction

   always @(posedge clk) begin
      for (int c = 0; c < NC; c++) begin
         for (int a = 7; a > 0; a--) begin
            mv[c][a] <= mv[c][a-1];
            md[c][a] <= md[c][a-1];
            mw[c][a] <= mw[c][a-1];
            ml[c][a] <= ml[c][a-1];
         end
         if (reset) begin
            for (int a = 0; a < 8; a++) mv[c][a] <= 1'b0;
            m_rs[c]  <= 2'd0;
            m_rt[c]  <= 2'd0;
            mp_st[c] <= 0;
            mp_fl[c] <= 0;
         end else begin
            mv[c][0] <= id_valid && !flush && !m_stall(c);
            md[c][0] <= id_dst;
            mw[c][0] <= id_regwrite;
            ml[c][0] <= id_memread;
            m_rs[c]  <= m_sel(c, id_rs, id_use_rs);
            m_rt[c]  <= m_sel(c, id_rt, id_use_rt);
            if (m_stall(c) && mp_st[c] < 65535) mp_st[c] <= mp_st[c] + 1;
            if (flush && mp_fl[c] < 65535) mp_fl[c] <= mp_fl[c] + 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         for (int c = 0; c < NC; c++) begin
            chk($sformatf("model_stall%0d", c), 16'(st[c]), 16'(m_stall(c)));
            chk($sformatf("model_sel_rs%0d", c), 16'(srs[c]), 16'(m_rs[c]));
            chk($sformatf("model_sel_rt%0d", c), 16'(srt[c]), 16'(m_rt[c]));
`ifdef HAZARD_SB_PERF_EN
            chk($sformatf("model_perf_stall%0d", c), pst[c], 16'(mp_st[c]));
            chk($sformatf("model_perf_flush%0d", c), pfl[c], 16'(mp_fl[c]));
`endif
         end
      end
   end

   task automatic step(input logic v, input logic [4:0] a_rs, input logic [4:0] a_rt,
                       input logic u_rs, input logic u_rt, input logic [4:0] a_dst,
                       input logic rw, input logic ld, input logic fl);
      @(posedge clk);
      #1;
      id_valid = v; id_rs = a_rs; id_rt = a_rt; id_use_rs = u_rs; id_use_rt = u_rt;
      id_dst = a_dst; id_regwrite = rw; id_memread = ld; flush = fl;
   endtask

   task automatic nop();
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
      step(1'b1, s, t, 1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic lw(input logic [4:0] d, input logic [4:0] base);
      step(1'b1, base, 5'd0, 1'b1, 1'b0, d, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic drain();
      repeat (3) nop();
   endtask

   initial begin
      reset = 1'b1;
      id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd0; id_use_rs = 1'b1; id_use_rt = 1'b0;
      id_dst = 5'd0; id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0;

      // Reset held 3 cycles with a reader of $3 in ID.
      @(posedge clk); #1; started = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_stall", 16'(st[0]), 16'd0);
         chk("rst_sel_rs", 16'(srs[0]), 16'd0);
         if (k < 2) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk); chk("post_rst_sel_rs", 16'(srs[0]), 16'd0);
      drain();

      // Back-to-back ALU dependency, then one and two nops of separation.
      alu(5'd3, 5'd1, 5'd2); alu(5'd5, 5'd3, 5'd2); nop();
      @(negedge clk); chk("adj_sel0", 16'(srs[0]), 16'd1); chk("adj_sel1", 16'(srs[1]), 16'd1);
      drain();
      alu(5'd3, 5'd1, 5'd2); nop(); alu(5'd5, 5'd3, 5'd2); nop();
      @(negedge clk); chk("gap1_sel0", 16'(srs[0]), 16'd2); chk("gap1_sel1", 16'(srs[1]), 16'd2);
      drain();
      alu(5'd3, 5'd1, 5'd2); nop(); nop(); alu(5'd5, 5'd3, 5'd2); nop();
      @(negedge clk); chk("gap2_sel0", 16'(srs[0]), 16'd0); chk("gap2_sel1", 16'(srs[1]), 16'd3);
      drain();

      // Load-use: consumer held in ID while stalled.
      lw(5'd4, 5'd1);
      alu(5'd5, 5'd4, 5'd4);
      @(negedge clk); chk("lu_b_stall0", 16'(st[0]), 16'd1); chk("lu_b_stall1", 16'(st[1]), 16'd1);
      alu(5'd5, 5'd4, 5'd4);
      @(negedge clk); chk("lu_c_stall0", 16'(st[0]), 16'd0); chk("lu_c_stall1", 16'(st[1]), 16'd1);
      alu(5'd5, 5'd4, 5'd4);
      @(negedge clk);
      chk("lu_d_stall1", 16'(st[1]), 16'd0);
      chk("lu_sel_rs0", 16'(srs[0]), 16'd2); chk("lu_sel_rt0", 16'(srt[0]), 16'd2);
      nop();
      @(negedge clk); chk("lu_sel_rs1", 16'(srs[1]), 16'd3); chk("lu_sel_rt1", 16'(srt[1]), 16'd3);
      drain();

      // Writes to $0 never forward or stall.
      alu(5'd0, 5'd1, 5'd2); alu(5'd6, 5'd0, 5'd0);
      @(negedge clk); chk("r0_stall", 16'(st[0]), 16'd0);
      nop();
      @(negedge clk); chk("r0_sel_rs", 16'(srs[0]), 16'd0); chk("r0_sel_rt", 16'(srt[0]), 16'd0);
      drain();

      // Flush wins over a load-use stall.
      lw(5'd4, 5'd1);
      step(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
      @(negedge clk); chk("fl_stall0", 16'(st[0]), 16'd0); chk("fl_stall1", 16'(st[1]), 16'd0);
      nop();
      @(negedge clk); chk("fl_sel_rs", 16'(srs[0]), 16'd0); chk("fl_sel_rt", 16'(srt[0]), 16'd0);
      drain();

      // Youngest of two writers of $7 wins.
      alu(5'd7, 5'd1, 5'd2); alu(5'd7, 5'd1, 5'd2); alu(5'd8, 5'd7, 5'd9); nop();
      @(negedge clk); chk("young_sel0", 16'(srs[0]), 16'd1); chk("young_sel1", 16'(srs[1]), 16'd1);
      drain();

      // Two sources hitting different entries.
      alu(5'd1, 5'd10, 5'd11); alu(5'd2, 5'd10, 5'd11); alu(5'd12, 5'd2, 5'd1); nop();
      @(negedge clk); chk("two_sel_rs", 16'(srs[0]), 16'd1); chk("two_sel_rt", 16'(srt[0]), 16'd2);
      drain();

      // Invalid ID slot never forwards.
      alu(5'd13, 5'd10, 5'd11);
      step(1'b0, 5'd13, 5'd13, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
      nop();
      @(negedge clk); chk("inv_sel_rs", 16'(srs[0]), 16'd0);
      drain();

      // Reset asserted mid-stall clears the scoreboard at the next edge.
      lw(5'd4, 5'd1);
      alu(5'd5, 5'd4, 5'd4); reset = 1'b1;
      @(negedge clk); chk("rms_stall_before", 16'(st[0]), 16'd1);
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk); chk("rms_stall0", 16'(st[0]), 16'd0); chk("rms_stall1", 16'(st[1]), 16'd0);
      drain();

`ifdef HAZARD_SB_PERF_EN
      @(negedge clk); chk("perf_stall_lit", pst[0], 16'd0); chk("perf_flush_lit", pfl[0], 16'd0);
`endif

      @(negedge clk);
      started = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
